// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port between NUM_REQ requesters.
// Define SPRITE_ARB_LOCK_EN to build the burst-lock FSM (ARB/LOCKED) and lock counter.
module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned AW       = 11,
  parameter int unsigned DW       = 6,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ-1:0]    lock,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [AW-1:0]         rom_addr,
  input  logic [DW-1:0]         rom_q,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [AW-1:0]      rom_addr_q, rom_addr_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] tag_q [ROM_LAT];
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DW-1:0]      rdata_q;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [PW-1:0]      win;
  logic [PW-1:0]      pick_idx;

`ifdef SPRITE_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [0:0] {StArb, StLocked} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock;
  assign unused_lock = ^{lock, MAX_LOCK};
`endif

  // Arbitration: eligible set, round-robin pick from ptr, next grant/address/pointer.
  always_comb begin
    elig = req & ~gnt_q;
`ifdef SPRITE_ARB_LOCK_EN
    // While locked only the owner competes, and it may be re-granted every cycle.
    if (state_q == StLocked && lock[owner_q]) begin
      elig           = '0;
      elig[owner_q]  = req[owner_q];
    end
`endif
    found    = 1'b0;
    win      = '0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pick_idx = PW'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && elig[pick_idx]) begin
        found = 1'b1;
        win   = pick_idx;
      end
    end

    gnt_d      = '0;
    rom_addr_d = rom_addr_q;
    ptr_d      = ptr_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win == PW'(i)) begin
          rom_addr_d = addr[i*AW +: AW];
        end
      end
      ptr_d = PW'((32'(win) + 1) % NUM_REQ);
    end
  end

`ifdef SPRITE_ARB_LOCK_EN
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      StArb: begin
        if (found && lock[win]) begin
          state_d    = StLocked;
          owner_d    = win;
          lock_cnt_d = '0;
        end
      end
      StLocked: begin
        if (!lock[owner_q]) begin
          // Owner let go: this cycle arbitrated normally, so a new locker may take over.
          if (found && lock[win]) begin
            owner_d    = win;
            lock_cnt_d = '0;
          end else begin
            state_d    = StArb;
            lock_cnt_d = '0;
          end
        end else if (found) begin
          if (lock_cnt_q == CW'(MAX_LOCK - 1)) begin
            state_d    = StArb;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = StArb;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StArb;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= '0;
      rom_addr_q <= '0;
      ptr_q      <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rom_addr_q <= rom_addr_d;
      ptr_q      <= ptr_d;
    end
  end

  // Tag pipeline follows the read through the ROM; rvalid is its final stage.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      tag_q[0] <= gnt_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      rvalid_q <= tag_q[ROM_LAT-1];
      rdata_q  <= rom_q;
    end
  end

  assign gnt      = gnt_q;
  assign rom_addr = rom_addr_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule
